perm_odd_pipe_ctrl: RTL and testbench
=====================================

Name: perm_odd_pipe_ctrl

Overview:
- Sequencer for the SPU odd-pipe permute/shift quadword datapath.
- Accepts one issued permute-class instruction per cycle through a valid/ready handshake and computes the byte/bit shift or rotate of RA.
- Carries the result and its target register through a fixed-latency pipeline with stall, flush and backpressure.
- Exposes an in-flight target-register check so issue logic can interlock against pending writes.

Parameters:
- LAT, 4, number of pipeline stages from accept to result-valid (min 2, max 8).
- AW, 7, register-file address width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  issue slot holds a permute op.
- in_ready  output  1  op is accepted this cycle when in_valid and in_ready are both high.
- in_op  input  3  000 shlqby, 001 rotqby, 010 shlqbi, 011 rotqbi, 100 shlqbyi; 101-111 illegal.
- in_ra  input  128  operand RA, bits [0:127], byte 0 = bits 0:7, most significant.
- in_rb  input  128  operand RB; only the count field is used.
- in_imm  input  7  I7 immediate, used by shlqbyi only.
- in_rt  input  AW  destination register.
- flush  input  1  discard all in-flight ops.
- out_valid  output  1  result present at final stage.
- out_ready  input  1  consumer (register-file write port) accepts the result.
- out_result  output  128  shifted/rotated quadword.
- out_rt  output  AW  destination of out_result.
- out_err  output  1  op was illegal; out_result = 0.
- chk_rt  input  AW  register address queried by issue logic.
- chk_hit  output  1  some valid stage (including the output stage) targets chk_rt.
- occupancy  output  4  count of valid stages, 0..LAT.

Behaviour:
- Reset (asynchronous, rst=1): all stage valids 0, out_result 0, out_rt 0, out_err 0, occupancy 0.
  - in_ready is combinational and reads 1 once valids are 0.
- advance = !out_valid || out_ready.
  - in_ready = advance.
  - When advance is 1, every stage shifts forward one position and stage 0 loads the accepted op, or a bubble if none is accepted.
  - When advance is 0, all stages hold.
- Latency: an op accepted at edge N presents out_valid at edge N+LAT-1 when there is no backpressure. Full throughput is one op per cycle.
- Datapath is computed combinationally at accept and registered into stage 0. Later stages only carry data.
- Shift and rotate rules (result byte b comes from RA byte (b+s)):
  - shlqby: s = rb[27:31]. s > 15 gives all zeros; otherwise byte b = ra byte b+s for b+s < 16, else 0.
  - rotqby: s = rb[28:31]; byte b = ra byte (b+s) mod 16.
  - shlqbi: s = rb[29:31] (0..7 bits); 128-bit logical left shift, zero fill on the right.
  - rotqbi: s = rb[29:31]; 128-bit rotate left by s bits.
  - shlqbyi: s = imm[2:6]; same rules as shlqby.
  - Illegal op: result 0, err bit 1. The op still flows through the pipeline and writes its rt.
- Flush: at the edge where flush=1, all stage valids clear.
  - An op accepted in the same cycle is also discarded; flush has priority over accept.
  - Flush overrides backpressure.
  - occupancy reads 0 the following cycle.
- chk_hit: combinational OR over valid stages of (stage_rt == chk_rt). Invalid stages never hit.
- occupancy: popcount of stage valids, updated every edge.
- Mid-operation reset clears everything immediately, without waiting for an edge.

Test Plan:
- shlqby, ra = 0x00112233_44556677_8899AABB_CCDDEEFF, rb[27:31]=3 -> out_result 0x33445566_778899AA_BBCCDDEE_FF000000 after LAT cycles, with out_err 0.
- shlqby with s=16 -> all zeros. rotqby with rb[28:31]=1 on the same ra -> 0x11223344_…_EEFF00. shlqbi with s=4 on ra = 0x8000…0001 -> 0x000…0010.
- Back-to-back 6 ops with out_ready=1 -> 6 results on consecutive cycles, in order, with matching out_rt. Pulling out_ready=0 for 3 cycles -> in_ready=0, outputs hold, occupancy=LAT.
- Issue to rt=5, then drive chk_rt=5 -> chk_hit=1 from the cycle after accept until the result is accepted at output; chk_rt=6 -> 0.
- flush asserted together with in_valid while 3 ops are in flight -> no out_valid afterwards, occupancy=0 next cycle.
- in_op=110 -> out_err=1 and out_result=0. rst asserted mid-stream -> out_valid drops immediately.

Source files
------------

// File: rtl/perm_odd_pipe_ctrl.sv
// rtl/perm_odd_pipe_ctrl.sv - SPU odd-pipe permute/shift sequencer with fixed-latency pipeline
// Operands use big-endian bit numbering [0:127]; byte 0 is the most significant byte.
module perm_odd_pipe_ctrl #(
   parameter int LAT = 4,
   parameter int AW  = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_op,
   input  logic [0:127]  in_ra,
   input  logic [0:127]  in_rb,
   input  logic [0:6]    in_imm,
   input  logic [AW-1:0] in_rt,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [0:127]  out_result,
   output logic [AW-1:0] out_rt,
   output logic          out_err,
   input  logic [AW-1:0] chk_rt,
   output logic          chk_hit,
   output logic [3:0]    occupancy
);

   function automatic logic [0:127] shl_bytes(input logic [0:127] a, input logic [4:0] s);
      logic [0:127] r;
      r = '0;
      if (s < 5'd16) r = a << {s, 3'b000};
      return r;
   endfunction

   // A shift by 128 yields zero, so n = 0 needs no special case.
   function automatic logic [0:127] rot_left(input logic [0:127] a, input logic [7:0] n);
      return (a << n) | (a >> (8'd128 - n));
   endfunction

   logic [0:127]  dp_result;
   logic          dp_err;
   logic          advance;
   logic          accept;
   logic          unused_bits;

   logic [LAT-1:0] vld_q, vld_d;
   logic [LAT-1:0] err_q, err_d;
   logic [0:127]   res_q [LAT];
   logic [0:127]   res_d [LAT];
   logic [AW-1:0]  rt_q  [LAT];
   logic [AW-1:0]  rt_d  [LAT];

   assign unused_bits = ^{in_rb[0:26], in_rb[32:127], in_imm[0:1]};

   always_comb begin
      dp_result = '0;
      dp_err    = 1'b0;
      case (in_op)
         3'b000:  dp_result = shl_bytes(in_ra, in_rb[27:31]);
         3'b001:  dp_result = rot_left(in_ra, {1'b0, in_rb[28:31], 3'b000});
         3'b010:  dp_result = in_ra << in_rb[29:31];
         3'b011:  dp_result = rot_left(in_ra, {5'b00000, in_rb[29:31]});
         3'b100:  dp_result = shl_bytes(in_ra, in_imm[2:6]);
         default: dp_err    = 1'b1;
      endcase
   end

   assign out_valid  = vld_q[LAT-1];
   assign out_result = res_q[LAT-1];
   assign out_rt     = rt_q[LAT-1];
   assign out_err    = err_q[LAT-1];
   assign advance    = !out_valid || out_ready;
   assign in_ready   = advance;
   assign accept     = in_valid && in_ready;

   always_comb begin
      vld_d = vld_q;
      err_d = err_q;
      res_d = res_q;
      rt_d  = rt_q;
      if (advance) begin
         for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            res_d[i] = res_q[i-1];
            rt_d[i]  = rt_q[i-1];
         end
         vld_d[0] = accept;
         err_d[0] = dp_err;
         res_d[0] = dp_result;
         rt_d[0]  = in_rt;
      end
      // Flush wins over both accept and backpressure.
      if (flush) vld_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         err_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            res_q[i] <= '0;
            rt_q[i]  <= '0;
         end
      end else begin
         vld_q <= vld_d;
         err_q <= err_d;
         res_q <= res_d;
         rt_q  <= rt_d;
      end
   end

   always_comb begin
      chk_hit   = 1'b0;
      occupancy = '0;
      for (int i = 0; i < LAT; i++) begin
         if (vld_q[i] && (rt_q[i] == chk_rt)) chk_hit = 1'b1;
         occupancy = occupancy + {3'b000, vld_q[i]};
      end
   end

endmodule

// File: tb/tb_perm_odd_pipe_ctrl.sv
// tb/tb_perm_odd_pipe_ctrl.sv - directed self-checking bench for perm_odd_pipe_ctrl
module tb_perm_odd_pipe_ctrl;
   localparam int LAT = 4;
   localparam int AW  = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_op;
   logic [127:0]  in_ra;
   logic [127:0]  in_rb;
   logic [6:0]    in_imm;
   logic [AW-1:0] in_rt;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  out_result;
   logic [AW-1:0] out_rt;
   logic          out_err;
   logic [AW-1:0] chk_rt;
   logic          chk_hit;
   logic [3:0]    occupancy;

   int checks = 0;
   int errors = 0;

   logic [2:0]    op_t  [8];
   logic [127:0]  ra_t  [8];
   logic [127:0]  rb_t  [8];
   logic [6:0]    imm_t [8];
   logic [AW-1:0] rt_t  [8];
   logic [127:0]  res_t [8];
   logic          err_t [8];

   always #5 clk = ~clk;

   perm_odd_pipe_ctrl #(.LAT(LAT), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .in_rt(in_rt),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_rt(out_rt), .out_err(out_err),
      .chk_rt(chk_rt), .chk_hit(chk_hit), .occupancy(occupancy)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i);
      in_valid = 1'b1;
      in_op    = op_t[i];
      in_ra    = ra_t[i];
      in_rb    = rb_t[i];
      in_imm   = imm_t[i];
      in_rt    = rt_t[i];
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic check_out(input string tag, input int i);
      check({tag, "_valid"},  out_valid,  1'b1);
      check({tag, "_result"}, out_result, res_t[i]);
      check({tag, "_rt"},     out_rt,     rt_t[i]);
      check({tag, "_err"},    out_err,    err_t[i]);
   endtask

   initial begin
      op_t[0] = 3'b000; ra_t[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      rb_t[0] = {32'h0000_0003, 96'h0};
      res_t[0] = 128'h33445566_778899AA_BBCCDDEE_FF000000;
      op_t[1] = 3'b000; ra_t[1] = ra_t[0];
      rb_t[1] = {32'hFFFF_FFF0, {96{1'b1}}};
      res_t[1] = 128'h0;
      op_t[2] = 3'b001; ra_t[2] = ra_t[0];
      rb_t[2] = {32'h0000_0001, 96'h0};
      res_t[2] = 128'h11223344_55667788_99AABBCC_DDEEFF00;
      op_t[3] = 3'b001; ra_t[3] = ra_t[0];
      rb_t[3] = {32'h0000_001F, 96'h0};
      res_t[3] = 128'hFF001122_33445566_778899AA_BBCCDDEE;
      op_t[4] = 3'b010; ra_t[4] = 128'h80000000_00000000_00000000_00000001;
      rb_t[4] = {32'h0000_00FC, 96'h0};
      res_t[4] = 128'h00000000_00000000_00000000_00000010;
      op_t[5] = 3'b011; ra_t[5] = ra_t[4];
      rb_t[5] = {32'h0000_0004, 96'h0};
      res_t[5] = 128'h00000000_00000000_00000000_00000018;
      op_t[6] = 3'b100; ra_t[6] = ra_t[0];
      rb_t[6] = {32'h0000_0007, 96'h0};
      res_t[6] = 128'h22334455_66778899_AABBCCDD_EEFF0000;
      op_t[7] = 3'b110; ra_t[7] = ra_t[0];
      rb_t[7] = {32'h0000_0001, 96'h0};
      res_t[7] = 128'h0;
      for (int i = 0; i < 8; i++) begin
         imm_t[i] = 7'b0000001;
         rt_t[i]  = AW'(i + 1);
         err_t[i] = (i == 7);
      end
      imm_t[6] = 7'b1100010;

      rst = 1'b1; in_valid = 1'b0; in_op = '0; in_ra = '0; in_rb = '0;
      in_imm = '0; in_rt = '0; flush = 1'b0; out_ready = 1'b1; chk_rt = '0;
      step(); step();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_occupancy", occupancy, 4'd0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_result", out_result, 128'h0);
      check("rst_out_rt", out_rt, '0);
      check("rst_out_err", out_err, 1'b0);
      rst = 1'b0;
      step();

      // Back-to-back stream of 8 ops, full throughput.
      for (int k = 0; k <= 10; k++) begin
         if (k < 8) drive(k); else idle();
         step();
         if (k < 8) check("stream_in_ready", in_ready, 1'b1);
         if (k == 2) check("stream_occ3", occupancy, 4'd3);
         if (k == 5) check("stream_occ_full", occupancy, 4'd4);
         if (k < 3) check("stream_latency", out_valid, 1'b0);
         else check_out("stream", k - 3);
      end
      step();
      check("stream_drained_valid", out_valid, 1'b0);
      check("stream_drained_occ", occupancy, 4'd0);

      // Backpressure: fill, hold three cycles, then drain in order.
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(k);
         step();
      end
      drive(4);
      #1;
      check("bp_full_occ", occupancy, 4'd4);
      check("bp_in_ready_low", in_ready, 1'b0);
      for (int h = 0; h < 3; h++) begin
         step();
         check("bp_hold_in_ready", in_ready, 1'b0);
         check("bp_hold_occ", occupancy, 4'd4);
         check_out("bp_hold", 0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", in_ready, 1'b1);
      step();
      idle();
      check_out("bp_drain", 1);
      for (int j = 2; j <= 4; j++) begin
         step();
         check_out("bp_drain", j);
      end
      step();
      check("bp_drained_valid", out_valid, 1'b0);

      // In-flight target check on rt=5.
      chk_rt = 7'd5;
      #1;
      check("chk_empty", chk_hit, 1'b0);
      drive(4);
      step();
      idle();
      check("chk_stage0", chk_hit, 1'b1);
      step();
      check("chk_stage1", chk_hit, 1'b1);
      step();
      check("chk_stage2", chk_hit, 1'b1);
      chk_rt = 7'd6;
      #1;
      check("chk_other_rt", chk_hit, 1'b0);
      chk_rt = 7'd5;
      step();
      check("chk_out_valid", out_valid, 1'b1);
      check("chk_out_stage", chk_hit, 1'b1);
      step();
      check("chk_after_write", chk_hit, 1'b0);
      check("chk_after_valid", out_valid, 1'b0);

      // Flush with an accept in the same cycle.
      for (int k = 0; k < 3; k++) begin
         drive(k);
         step();
      end
      check("flush_pre_occ", occupancy, 4'd3);
      drive(3);
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle();
      check("flush_occ", occupancy, 4'd0);
      check("flush_valid", out_valid, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step();
         check("flush_no_out", out_valid, 1'b0);
      end

      // Flush while stalled by backpressure.
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(k);
         step();
      end
      idle();
      check("flush_bp_pre_valid", out_valid, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_bp_occ", occupancy, 4'd0);
      check("flush_bp_valid", out_valid, 1'b0);
      check("flush_bp_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;

      // Asynchronous reset in the middle of a cycle.
      for (int k = 0; k < 4; k++) begin
         drive(k);
         step();
      end
      idle();
      check("mid_pre_valid", out_valid, 1'b1);
      chk_rt = 7'd1;
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_occ", occupancy, 4'd0);
      check("mid_rst_result", out_result, 128'h0);
      check("mid_rst_chk_hit", chk_hit, 1'b0);
      step();
      rst = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
